// File: rtl/seq_datapath_pkg.sv
// -----------------------------------------------------------------------------
// seq_datapath_pkg
// Shared types and helpers for the self-sequencing datapath:
//   op_t     - 4-bit operation code
//   state_t  - micro-step FSM state
//   C2_*     - BRCHK condition-select encodings
//   sext()   - sign extension from an arbitrary width up to MAX_W bits
// Optional feature macro used by importers: SEQ_DATAPATH_MUL_EN
// -----------------------------------------------------------------------------
package seq_datapath_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SHR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_ROR   = 4'd6,
        OP_ROL   = 4'd7,
        OP_ADDI  = 4'd8,
        OP_MUL   = 4'd9,
        OP_MFHI  = 4'd10,
        OP_MFLO  = 4'd11,
        OP_BRCHK = 4'd12,
        OP_OUT   = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    localparam logic [1:0] C2_ZERO = 2'b00;
    localparam logic [1:0] C2_NZ   = 2'b01;
    localparam logic [1:0] C2_GE   = 2'b10;
    localparam logic [1:0] C2_LT   = 2'b11;

    // Replicates bit w-1 of v into every bit at or above w.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < w) ? v[i] : v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_datapath_alu.sv
// -----------------------------------------------------------------------------
// seq_datapath_alu
// Purely combinational operation unit for seq_datapath.
// Ports:
//   a   in  DATA_W  first operand (Y, i.e. Rb)
//   b   in  DATA_W  second operand (Rc, sign-extended immediate, HI or LO)
//   op  in  op_t    operation
//   lo  out DATA_W  result word (lower product half for MUL)
//   hi  out DATA_W  upper product half (only with SEQ_DATAPATH_MUL_EN)
// MFHI/MFLO pass b through, BRCHK/OUT pass a through, illegal ops give 0.
// -----------------------------------------------------------------------------
module seq_datapath_alu
    import seq_datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_t               op,
`ifdef SEQ_DATAPATH_MUL_EN
    output logic [DATA_W-1:0] hi,
`endif
    output logic [DATA_W-1:0] lo
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]     shamt;
    logic [2*DATA_W-1:0] rot_r;
    logic [2*DATA_W-1:0] rot_l;

    assign shamt = b[SH_W-1:0];
    // Rotates shift a doubled copy so the wrapped bits fall into place.
    assign rot_r = {a, a} >> shamt;
    assign rot_l = {a, a} << shamt;

`ifdef SEQ_DATAPATH_MUL_EN
    logic [2*DATA_W-1:0] prod;
    // Signed product: sign-extend both operands to 2*DATA_W, keep low half.
    assign prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
`endif

    always_comb begin
        lo = '0;
`ifdef SEQ_DATAPATH_MUL_EN
        hi = '0;
`endif
        case (op)
            OP_ADD, OP_ADDI:  lo = a + b;
            OP_SUB:           lo = a - b;
            OP_AND:           lo = a & b;
            OP_OR:            lo = a | b;
            OP_SHR:           lo = a >> shamt;
            OP_SHL:           lo = a << shamt;
            OP_ROR:           lo = rot_r[DATA_W-1:0];
            OP_ROL:           lo = rot_l[2*DATA_W-1:DATA_W];
            OP_BRCHK, OP_OUT: lo = a;
`ifdef SEQ_DATAPATH_MUL_EN
            OP_MUL: begin
                lo = prod[DATA_W-1:0];
                hi = prod[2*DATA_W-1:DATA_W];
            end
            OP_MFHI, OP_MFLO: lo = b;
`endif
            default:          lo = '0;
        endcase
    end

endmodule

// File: rtl/seq_datapath.sv
// -----------------------------------------------------------------------------
// seq_datapath
// Self-sequencing register-transfer datapath. One command is executed at a
// time through the micro-steps IDLE -> T1 -> T2 -> T3 -> RSP.
// Ports:
//   clock        in   rising-edge clock
//   clear        in   asynchronous active-low reset
//   cmd_valid    in   command present
//   cmd_ready    out  high in IDLE; command accepted when high with cmd_valid
//   cmd_op       in   operation code (op_t)
//   cmd_ra/rb/rc in   destination / source A / source B register index
//   cmd_imm      in   immediate, sign-extended to DATA_W
//   cmd_c2       in   BRCHK condition select
//   rsp_valid    out  result available, held until taken with rsp_ready
//   rsp_ready    in   consumer takes result
//   rsp_data     out  result word
//   rsp_flag     out  BRCHK outcome (0 for other ops)
//   rsp_err      out  illegal op
//   out_port     out  out-port register
//   con_out      out  latched condition flag
//   fsm_state    out  current micro-step, for observation
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until that edge, and ready may be
// asserted independently of valid.
// Macro SEQ_DATAPATH_MUL_EN adds HI/LO, MUL, MFHI and MFLO; without it ops
// 9-11 are reported as illegal.
// -----------------------------------------------------------------------------
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int IMM_W  = 19,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [AW-1:0]     cmd_ra,
    input  logic [AW-1:0]     cmd_rb,
    input  logic [AW-1:0]     cmd_rc,
    input  logic [IMM_W-1:0]  cmd_imm,
    input  logic [1:0]        cmd_c2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_flag,
    output logic              rsp_err,
    output logic [DATA_W-1:0] out_port,
    output logic              con_out,
    output state_t            fsm_state
);

    state_t              state;
    op_t                 op_q;
    logic [AW-1:0]       ra_q;
    logic [AW-1:0]       rb_q;
    logic [AW-1:0]       rc_q;
    logic [IMM_W-1:0]    imm_q;
    logic [1:0]          c2_q;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   y_q;
    logic [DATA_W-1:0]   z_q;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   opnd_b;
    logic [DATA_W-1:0]   alu_lo;
    logic                legal;
    logic                writes_ra;
    logic                cond;

`ifdef SEQ_DATAPATH_MUL_EN
    logic [DATA_W-1:0]   zh_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   alu_hi;
`endif

    assign cmd_ready = (state == ST_IDLE);
    assign fsm_state = state;
    assign imm_ext   = DATA_W'(sext(MAX_W'(imm_q), IMM_W));

    // R0 always reads as zero regardless of register contents.
    function automatic logic [DATA_W-1:0] rd(input logic [AW-1:0] idx);
        return (idx == '0) ? '0 : regs[idx];
    endfunction

    // Second operand chosen during T2.
    always_comb begin
        opnd_b = rd(rc_q);
        case (op_q)
            OP_ADDI: opnd_b = imm_ext;
`ifdef SEQ_DATAPATH_MUL_EN
            OP_MFHI: opnd_b = hi_q;
            OP_MFLO: opnd_b = lo_q;
`endif
            default: opnd_b = rd(rc_q);
        endcase
    end

    always_comb begin
        legal     = 1'b1;
        writes_ra = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ADDI: writes_ra = 1'b1;
`ifdef SEQ_DATAPATH_MUL_EN
            OP_MFHI, OP_MFLO:                         writes_ra = 1'b1;
            OP_MUL:                                   legal     = 1'b1;
`endif
            OP_BRCHK, OP_OUT:                         legal     = 1'b1;
            default:                                  legal     = 1'b0;
        endcase
    end

    // BRCHK condition evaluated on Z, which holds Rb by T3.
    always_comb begin
        cond = 1'b0;
        case (c2_q)
            C2_ZERO: cond = (z_q == '0);
            C2_NZ:   cond = (z_q != '0);
            C2_GE:   cond = ~z_q[DATA_W-1];
            C2_LT:   cond = z_q[DATA_W-1];
            default: cond = 1'b0;
        endcase
    end

    seq_datapath_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a  (y_q),
        .b  (opnd_b),
        .op (op_q),
`ifdef SEQ_DATAPATH_MUL_EN
        .hi (alu_hi),
`endif
        .lo (alu_lo)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            imm_q     <= '0;
            c2_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            rsp_err   <= 1'b0;
            out_port  <= '0;
            con_out   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
`ifdef SEQ_DATAPATH_MUL_EN
            zh_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= op_t'(cmd_op);
                        ra_q  <= cmd_ra;
                        rb_q  <= cmd_rb;
                        rc_q  <= cmd_rc;
                        imm_q <= cmd_imm;
                        c2_q  <= cmd_c2;
                        state <= ST_T1;
                    end
                end
                ST_T1: begin
                    y_q   <= rd(rb_q);
                    state <= ST_T2;
                end
                ST_T2: begin
                    z_q   <= alu_lo;
`ifdef SEQ_DATAPATH_MUL_EN
                    zh_q  <= alu_hi;
`endif
                    state <= ST_T3;
                end
                ST_T3: begin
                    rsp_valid <= 1'b1;
                    rsp_flag  <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    if (!legal) begin
                        rsp_err <= 1'b1;
                    end else if (writes_ra) begin
                        // Writes to R0 are dropped but still reported.
                        if (ra_q != '0) begin
                            regs[ra_q] <= z_q;
                        end
                        rsp_data <= z_q;
                    end else if (op_q == OP_BRCHK) begin
                        con_out  <= cond;
                        rsp_flag <= cond;
                    end else if (op_q == OP_OUT) begin
                        out_port <= z_q;
                        rsp_data <= z_q;
                    end
`ifdef SEQ_DATAPATH_MUL_EN
                    else if (op_q == OP_MUL) begin
                        hi_q     <= zh_q;
                        lo_q     <= z_q;
                        rsp_data <= z_q;
                    end
`endif
                    state <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_datapath.sv
module tb_seq_datapath;
    import seq_datapath_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int IMM_W  = 19;
    localparam int AW     = 4;

    logic              clock;
    logic              clear;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [AW-1:0]     cmd_ra, cmd_rb, cmd_rc;
    logic [IMM_W-1:0]  cmd_imm;
    logic [1:0]        cmd_c2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_flag;
    logic              rsp_err;
    logic [DATA_W-1:0] out_port;
    logic              con_out;
    state_t            fsm_state;

    int n_vec = 0;
    int n_err = 0;

    seq_datapath #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
        .clock(clock), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
        .cmd_imm(cmd_imm), .cmd_c2(cmd_c2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flag(rsp_flag), .rsp_err(rsp_err),
        .out_port(out_port), .con_out(con_out), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one command, wait (bounded) for the response, capture it and
    // take it with rsp_ready. lat = edges from accept to rsp_valid.
    task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] ra,
                           input logic [AW-1:0] rb, input logic [AW-1:0] rc,
                           input logic [IMM_W-1:0] imm, input logic [1:0] c2,
                           output logic [DATA_W-1:0] data, output logic flag,
                           output logic err, output int lat);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb;
        cmd_rc = rc; cmd_imm = imm; cmd_c2 = c2;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        cmd_op = $urandom_range(0, 15);
        cmd_ra = $urandom_range(0, 15);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        data = rsp_data; flag = rsp_flag; err = rsp_err;
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0; cmd_imm = '0; cmd_c2 = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_vec++;
        if ({cmd_ready, rsp_valid, rsp_flag, rsp_err, con_out} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, rsp_valid, rsp_flag, rsp_err, con_out});
        end
        n_vec++;
        if (rsp_data !== 32'h0 || out_port !== 32'h0 || fsm_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_data: rsp_data %h out_port %h state %0d, want 0 0 0", rsp_data, out_port, fsm_state);
        end
        clear = 1'b1;
    endtask

    task automatic test_add();
        logic [DATA_W-1:0] d; logic f, e; int lat;
        run_cmd(4'd8, 4'd1, 4'd0, 4'd0, 19'd5, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd5 || lat !== 3) begin
            n_err++; $display("FAIL addi_r1: data %h lat %0d, want 00000005 3", d, lat);
        end
        run_cmd(4'd0, 4'd2, 4'd1, 4'd1, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd10 || lat !== 3 || f !== 1'b0 || e !== 1'b0) begin
            n_err++; $display("FAIL add_r2: data %h lat %0d flag %b err %b, want 0000000a 3 0 0", d, lat, f, e);
        end
        // Negative immediate boundary: all ones sign-extends to -1.
        run_cmd(4'd8, 4'd9, 4'd0, 4'd0, 19'h7FFFF, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL addi_neg: got %h want ffffffff", d);
        end
        // Write to R0 reports the value but leaves R0 at zero.
        run_cmd(4'd8, 4'd0, 4'd0, 4'd0, 19'd7, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd7) begin
            n_err++; $display("FAIL addi_r0: got %h want 00000007", d);
        end
        run_cmd(4'd13, 4'd0, 4'd0, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd0 || out_port !== 32'd0) begin
            n_err++; $display("FAIL r0_zero: data %h out_port %h, want 0 0", d, out_port);
        end
    endtask

    task automatic test_sub_brchk();
        logic [DATA_W-1:0] d; logic f, e; int lat;
        run_cmd(4'd1, 4'd3, 4'd0, 4'd1, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'hFFFFFFFB) begin
            n_err++; $display("FAIL sub_r3: got %h want fffffffb", d);
        end
        run_cmd(4'd12, 4'd0, 4'd3, 4'd0, 19'd0, 2'b11, d, f, e, lat);
        n_vec++;
        if (f !== 1'b1 || con_out !== 1'b1) begin
            n_err++; $display("FAIL brchk_lt: flag %b con %b, want 1 1", f, con_out);
        end
        run_cmd(4'd12, 4'd0, 4'd3, 4'd0, 19'd0, 2'b10, d, f, e, lat);
        n_vec++;
        if (f !== 1'b0 || con_out !== 1'b0) begin
            n_err++; $display("FAIL brchk_ge: flag %b con %b, want 0 0", f, con_out);
        end
        run_cmd(4'd12, 4'd0, 4'd0, 4'd0, 19'd0, 2'b00, d, f, e, lat);
        n_vec++;
        if (f !== 1'b1 || con_out !== 1'b1) begin
            n_err++; $display("FAIL brchk_zero: flag %b con %b, want 1 1", f, con_out);
        end
    endtask

    task automatic test_shift_rot();
        logic [DATA_W-1:0] d; logic f, e; int lat;
        run_cmd(4'd8, 4'd10, 4'd0, 4'd0, 19'd1, 2'd0, d, f, e, lat);
        run_cmd(4'd8, 4'd11, 4'd0, 4'd0, 19'd31, 2'd0, d, f, e, lat);
        run_cmd(4'd5, 4'd12, 4'd10, 4'd11, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'h80000000) begin
            n_err++; $display("FAIL shl31: got %h want 80000000", d);
        end
        run_cmd(4'd3, 4'd4, 4'd12, 4'd10, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'h80000001) begin
            n_err++; $display("FAIL or_r4: got %h want 80000001", d);
        end
        run_cmd(4'd7, 4'd13, 4'd4, 4'd10, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'h00000003) begin
            n_err++; $display("FAIL rol1: got %h want 00000003", d);
        end
        run_cmd(4'd4, 4'd14, 4'd4, 4'd10, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'h40000000) begin
            n_err++; $display("FAIL shr1: got %h want 40000000", d);
        end
        run_cmd(4'd6, 4'd15, 4'd4, 4'd10, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'hC0000000) begin
            n_err++; $display("FAIL ror1: got %h want c0000000", d);
        end
        run_cmd(4'd2, 4'd15, 4'd4, 4'd3, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'h80000001) begin
            n_err++; $display("FAIL and: got %h want 80000001", d);
        end
    endtask

    task automatic test_mul();
        logic [DATA_W-1:0] d; logic f, e; int lat;
`ifdef SEQ_DATAPATH_MUL_EN
        run_cmd(4'd8, 4'd5, 4'd0, 4'd0, 19'h7FFFE, 2'd0, d, f, e, lat);
        run_cmd(4'd8, 4'd6, 4'd0, 4'd0, 19'd3, 2'd0, d, f, e, lat);
        run_cmd(4'd9, 4'd0, 4'd5, 4'd6, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'hFFFFFFFA || e !== 1'b0) begin
            n_err++; $display("FAIL mul_lo: data %h err %b, want fffffffa 0", d, e);
        end
        run_cmd(4'd10, 4'd7, 4'd0, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL mfhi: got %h want ffffffff", d);
        end
        run_cmd(4'd11, 4'd7, 4'd0, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        run_cmd(4'd13, 4'd0, 4'd7, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'hFFFFFFFA || out_port !== 32'hFFFFFFFA) begin
            n_err++; $display("FAIL mflo_r7: data %h out %h, want fffffffa", d, out_port);
        end
`else
        run_cmd(4'd9, 4'd7, 4'd1, 4'd1, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (e !== 1'b1 || d !== 32'd0 || lat !== 3) begin
            n_err++; $display("FAIL mul_disabled: err %b data %h lat %0d, want 1 0 3", e, d, lat);
        end
        run_cmd(4'd13, 4'd0, 4'd7, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd0) begin
            n_err++; $display("FAIL mul_no_write: r7 %h want 0", d);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d; logic f, e; int lat; int stable_bad;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_ra = 4'd8; cmd_rb = 4'd2; cmd_rc = 4'd1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1; lat++;
        end
        n_vec++;
        if (rsp_data !== 32'd15 || lat !== 3) begin
            n_err++; $display("FAIL bp_add: data %h lat %0d, want 0000000f 3", rsp_data, lat);
        end
        // Competing command while the response is held off.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_ra = 4'd1; cmd_rb = 4'd0; cmd_imm = 19'd99;
        stable_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd15 || cmd_ready !== 1'b0 ||
                rsp_err !== 1'b0) stable_bad++;
        end
        n_vec++;
        if (stable_bad !== 0) begin
            n_err++; $display("FAIL bp_stable: %0d unstable cycles, want 0", stable_bad);
        end
        @(negedge clock);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: valid %b ready %b, want 0 1", rsp_valid, cmd_ready);
        end
        run_cmd(4'd13, 4'd0, 4'd1, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd5 || out_port !== 32'd5) begin
            n_err++; $display("FAIL bp_ignored: r1 %h out %h, want 5 5", d, out_port);
        end
        run_cmd(4'd14, 4'd2, 4'd1, 4'd1, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (e !== 1'b1 || d !== 32'd0 || f !== 1'b0) begin
            n_err++; $display("FAIL illegal14: err %b data %h flag %b, want 1 0 0", e, d, f);
        end
        run_cmd(4'd13, 4'd0, 4'd2, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd10 || e !== 1'b0) begin
            n_err++; $display("FAIL illegal_nowrite: r2 %h err %b, want a 0", d, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d; logic f, e; int lat;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_ra = 4'd1; cmd_rb = 4'd2; cmd_rc = 4'd2;
        @(posedge clock);          // accept -> T1
        #1 cmd_valid = 1'b0;
        @(posedge clock);          // -> T2
        #1;
        n_vec++;
        if (fsm_state !== ST_T2) begin
            n_err++; $display("FAIL mid_state: got %0d want %0d", fsm_state, ST_T2);
        end
        clear = 1'b0;
        #2;
        n_vec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || out_port !== 32'd0 || con_out !== 1'b0) begin
            n_err++; $display("FAIL mid_abort: valid %b ready %b out %h con %b, want 0 1 0 0",
                              rsp_valid, cmd_ready, out_port, con_out);
        end
        @(negedge clock);
        clear = 1'b1;
        run_cmd(4'd13, 4'd0, 4'd1, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (d !== 32'd0 || out_port !== 32'd0) begin
            n_err++; $display("FAIL mid_r1: r1 %h out %h, want 0 0", d, out_port);
        end
        run_cmd(4'd13, 4'd0, 4'd0, 4'd0, 19'd0, 2'd0, d, f, e, lat);
        n_vec++;
        if (out_port !== 32'd0 || lat !== 3) begin
            n_err++; $display("FAIL out_r0: out %h lat %0d, want 0 3", out_port, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_brchk();
        test_shift_rot();
        test_mul();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised, self-sequencing successor to the bus-based CPU datapath. It holds a register file, Y/Z staging registers, HI/LO, a condition flip-flop and an out-port. An internal micro-step FSM executes one register-transfer command at a time. Commands arrive on a valid/ready interface and results return on a valid/ready response channel, so a later control unit or a testbench drives whole operations rather than individual Rin/Rout strobes.

## Interface
- DATA_W, 32, datapath word width (≥8).
- NREGS, 16, register count (power of two, ≥4); AW = $clog2(NREGS).
- IMM_W, 19, immediate width (< DATA_W), sign-extended.
- clock  in  1  rising-edge clock.
- clear  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  4  operation code.
- cmd_ra / cmd_rb / cmd_rc  in  AW each  destination / source A / source B.
- cmd_imm  in  IMM_W  immediate.
- cmd_c2  in  2  condition select for BRCHK.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  DATA_W  result word.
- rsp_flag  out  1  BRCHK outcome, 0 for other ops.
- rsp_err  out  1  illegal op.
- out_port  out  DATA_W  out-port register.
- con_out  out  1  latched condition flag.

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHL, 6 ROR, 7 ROL, 8 ADDI (Rb + sext(imm)), 9 MUL, 10 MFHI, 11 MFLO, 12 BRCHK, 13 OUT; 14–15 illegal.
- R0 is hardwired zero: reads return 0 and writes are dropped.
- Shifts and rotates use Rc[$clog2(DATA_W)-1:0].
- Arithmetic wraps modulo 2^DATA_W.
- MUL is signed: the 2·DATA_W product goes to HI (upper) and LO (lower). Ra is not written; rsp_data = LO.
- MFHI / MFLO: Ra ← HI / LO.
- BRCHK tests Rb. c2 encoding: 00 = zero, 01 = nonzero, 10 = ≥0 (signed), 11 = <0. The result goes to con_out and rsp_flag; no register write.
- OUT: out_port ← Rb; rsp_data = Rb.
- Illegal op: no state change; rsp_err=1, rsp_data=0.
- All ALU ops other than MUL/BRCHK/OUT write Ra, and rsp_data = value written (including when Ra=R0).
- FSM states and transitions:
  - IDLE → T1 on accept; command fields are latched at accept.
  - T1 → T2: Y ← Rb.
  - T2 → T3: Z ← Y op (Rc or sext(imm)).
  - T3 → RSP: writeback, HI/LO or con/out-port update, and rsp_* are loaded.
  - RSP → IDLE when rsp_ready.
- cmd_ready = (state == IDLE).

## Timing
- Accept edge k. rsp_valid rises after edge k+3 and is held stable until the rsp_ready edge; it is cleared on that edge.
- Minimum period is 5 cycles per command: the rsp_ready edge, then the next accept on the following edge.
- A register written by command N is visible to command N+1.
- cmd_valid without cmd_ready is ignored. Field changes outside accept have no effect.
- rsp_ready while rsp_valid=0 has no effect.
- clear low at any time aborts the command; all registers, HI, LO, Y, Z, out_port and con_out go to 0; the FSM returns to IDLE.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_err=0, out_port=0, con_out=0.

## Configuration
- SEQ_DATAPATH_MUL_EN defined: MUL, MFHI and MFLO are implemented as above.
- SEQ_DATAPATH_MUL_EN undefined:
  - HI/LO and the multiplier are absent.
  - Ops 9–11 are illegal (rsp_err=1, no state change, same latency).

## Structure
- Package seq_datapath_pkg holds:
  - the op enum (4-bit);
  - the FSM state enum;
  - the c2 encoding constants;
  - a sext function.
- Sub-module seq_datapath_alu: combinational, returns {hi, lo} for every op from (a, b, op).
- The register file and FSM stay in the top module.

## Test plan
- Reset, then ADDI R1 = R0 + 5, then ADD R2 = R1 + R1:
  - rsp_data 5, then 10;
  - each rsp_valid appears 3 edges after accept.
- SUB R3 = R0 − R1 (R1=5) → rsp_data 0xFFFFFFFB. Then BRCHK Rb=R3 with c2=11 → rsp_flag=1, con_out=1.
- With R4=0x80000001 and Rc=1:
  - ROL → 0x00000003;
  - SHR → 0x40000000.
- MUL with R5=−2 and R6=3 (MUL_EN) → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFLO R7 writes 0xFFFFFFFA.
- Response back-pressure:
  - hold rsp_ready=0 for 4 cycles: rsp_* stay stable, cmd_ready=0, a new cmd_valid is ignored;
  - op 14 → rsp_err=1 and no register changes.
- Reset mid-command: pull clear low in T2 of ADD R1 → R1 reads 0 afterwards, rsp_valid=0, cmd_ready=1. OUT of R0 then gives out_port=0.
